// File: rtl/rca_wb_sequencer.sv
// Writeback sequencer: queues RCA completion groups and drains them one word
// per granted cycle onto the shared register-file write port, then retires each group.
module rca_wb_sequencer #(
  parameter int XLEN            = 32,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ID_W            = 3,
  parameter int DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_done,
  input  logic [ID_W-1:0]                 wb_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
  input  logic [NUM_WRITE_PORTS*5-1:0]    wb_rd_addr,
  input  logic [NUM_WRITE_PORTS-1:0]      wb_port_valid,
  output logic                            wb_ready,
  output logic                            rf_we,
  output logic [4:0]                      rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  input  logic                            rf_grant,
  output logic                            retire_valid,
  output logic [ID_W-1:0]                 retire_id,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy,
  output logic                            overflow_err
);

  // state | meaning
  // IDLE  | FIFO empty, nothing to write
  // SCAN  | head group draining from port index p upward

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_n;
  logic [PW-1:0] p, p_n;
  logic [AW:0]   wr_ptr, rd_ptr, wr_n, rd_n;
  logic          push, pop, full_n;

  logic [ID_W-1:0]                 id_mem   [DEPTH];
  logic [NUM_WRITE_PORTS*XLEN-1:0] data_mem [DEPTH];
  logic [NUM_WRITE_PORTS*5-1:0]    addr_mem [DEPTH];
  logic [NUM_WRITE_PORTS-1:0]      vld_mem  [DEPTH];

  logic [ID_W-1:0]                 head_id;
  logic [NUM_WRITE_PORTS*XLEN-1:0] head_data;
  logic [NUM_WRITE_PORTS*5-1:0]    head_addr;
  logic [NUM_WRITE_PORTS-1:0]      head_vld;
  logic [NUM_WRITE_PORTS-1:0]      push_vld;

  logic            found, more;
  int              qi;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  assign push      = wb_done && wb_ready;
  assign head_id   = id_mem[rd_ptr[AW-1:0]];
  assign head_data = data_mem[rd_ptr[AW-1:0]];
  assign head_addr = addr_mem[rd_ptr[AW-1:0]];
  assign head_vld  = vld_mem[rd_ptr[AW-1:0]];
  assign occupancy = OW'(wr_ptr - rd_ptr);

  // Writes to x0 are discarded at push so the drain never spends a grant on them.
  always_comb begin
    push_vld = '0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++)
      push_vld[i] = wb_port_valid[i] && (wb_rd_addr[i*5 +: 5] != 5'd0);
  end

  always_comb begin
    state_n      = state;
    p_n          = p;
    pop          = 1'b0;
    found        = 1'b0;
    more         = 1'b0;
    qi           = 0;
    sel_addr     = '0;
    sel_data     = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    retire_valid = 1'b0;
    retire_id    = '0;

    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      if (!found && (i >= int'(p)) && head_vld[i]) begin
        found    = 1'b1;
        qi       = i;
        sel_addr = head_addr[i*5 +: 5];
        sel_data = head_data[i*XLEN +: XLEN];
      end
    end
    for (int i = 0; i < NUM_WRITE_PORTS; i++)
      if (found && (i > qi) && head_vld[i]) more = 1'b1;

    case (state)
      IDLE: if (push) state_n = SCAN;
      SCAN: begin
        if (found) begin
          rf_we    = 1'b1;
          rf_waddr = sel_addr;
          rf_wdata = sel_data;
          if (rf_grant) begin
            if (more) p_n = PW'(qi + 1);
            else      pop = 1'b1;
          end
        end else begin
          pop = 1'b1;
        end
        if (pop) begin
          retire_valid = 1'b1;
          retire_id    = head_id;
          p_n          = '0;
        end
        // Staying in SCAN across a pop gives back-to-back groups with no bubble.
        if (pop && !push && (occupancy == OW'(1))) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wr_n   = wr_ptr + (AW+1)'(push);
  assign rd_n   = rd_ptr + (AW+1)'(pop);
  assign full_n = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      p            <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wb_ready     <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      state    <= state_n;
      p        <= p_n;
      wr_ptr   <= wr_n;
      rd_ptr   <= rd_n;
      wb_ready <= !full_n;
      if (wb_done && !wb_ready) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr[AW-1:0]]   <= wb_id;
      data_mem[wr_ptr[AW-1:0]] <= wb_rd;
      addr_mem[wr_ptr[AW-1:0]] <= wb_rd_addr;
      vld_mem[wr_ptr[AW-1:0]]  <= push_vld;
    end
  end

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// Self-checking bench for rca_wb_sequencer: directed scenarios plus a randomized
// drain checked against a queue-based model of groups, writes and retires.
module tb_rca_wb_sequencer;
  localparam int XLEN = 32, NWP = 2, ID_W = 3, DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wb_done;
  logic [ID_W-1:0]      wb_id;
  logic [NWP*XLEN-1:0]  wb_rd;
  logic [NWP*5-1:0]     wb_rd_addr;
  logic [NWP-1:0]       wb_port_valid;
  logic                 wb_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 rf_grant;
  logic                 retire_valid;
  logic [ID_W-1:0]      retire_id;
  logic [2:0]           occupancy;
  logic                 overflow_err;

  int checks = 0;
  int failures = 0;

  rca_wb_sequencer #(.XLEN(XLEN), .NUM_WRITE_PORTS(NWP), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_rd_addr(wb_rd_addr), .wb_port_valid(wb_port_valid), .wb_ready(wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_grant(rf_grant),
    .retire_valid(retire_valid), .retire_id(retire_id), .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    wb_done = 0; wb_id = '0; wb_rd = '0; wb_rd_addr = '0; wb_port_valid = '0;
  endtask

  task automatic do_reset;
    idle_inputs(); rf_grant = 0; rst = 1;
    #12; @(negedge clk); rst = 0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs(); rf_grant = 0; rst = 1;
    #3;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== '0) begin failures++; $display("FAIL reset_rf_bus got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    checks++; if (retire_valid !== 1'b0 || retire_id !== '0) begin failures++; $display("FAIL reset_retire got=%0b/%0d exp=0/0", retire_valid, retire_id); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready got=%0b exp=1", wb_ready); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow_err); end
    @(negedge clk); rst = 0;
    tick();
  endtask

  task automatic test_single;
    wb_done = 1; wb_id = 3'd5; wb_rd = {32'h12345678, 32'hDEADBEEF};
    wb_rd_addr = {5'd11, 5'd10}; wb_port_valid = 2'b11; rf_grant = 1;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_pre_we got=%0b exp=0", rf_we); end
    tick(); idle_inputs(); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_w0 got=%0b/%0d/%h exp=1/10/deadbeef", rf_we, rf_waddr, rf_wdata); end
    checks++; if (retire_valid !== 1'b0 || occupancy !== 3'd1) begin failures++; $display("FAIL single_c1 got ret=%0b occ=%0d exp ret=0 occ=1", retire_valid, occupancy); end
    tick(); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h12345678) begin failures++; $display("FAIL single_w1 got=%0b/%0d/%h exp=1/11/12345678", rf_we, rf_waddr, rf_wdata); end
    checks++; if (retire_valid !== 1'b1 || retire_id !== 3'd5) begin failures++; $display("FAIL single_retire got=%0b/%0d exp=1/5", retire_valid, retire_id); end
    tick(); #1;
    checks++; if (occupancy !== 3'd0 || rf_we !== 1'b0 || retire_valid !== 1'b0) begin failures++; $display("FAIL single_done got occ=%0d we=%0b ret=%0b exp 0/0/0", occupancy, rf_we, retire_valid); end
  endtask

  task automatic test_config;
    tick();
    wb_done = 1; wb_id = 3'd2; wb_rd = {$urandom, $urandom}; wb_rd_addr = {5'd3, 5'd4}; wb_port_valid = 2'b00;
    tick(); idle_inputs(); #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL config_we got=%0b exp=0", rf_we); end
    checks++; if (retire_valid !== 1'b1 || retire_id !== 3'd2) begin failures++; $display("FAIL config_retire got=%0b/%0d exp=1/2", retire_valid, retire_id); end
    tick();
    wb_done = 1; wb_id = 3'd3; wb_rd = {32'h1, 32'hCAFE0000}; wb_rd_addr = {5'd7, 5'd0}; wb_port_valid = 2'b11;
    tick(); idle_inputs(); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1) begin failures++; $display("FAIL x0_write got=%0b/%0d/%h exp=1/7/1", rf_we, rf_waddr, rf_wdata); end
    checks++; if (retire_valid !== 1'b1 || retire_id !== 3'd3) begin failures++; $display("FAIL x0_retire got=%0b/%0d exp=1/3", retire_valid, retire_id); end
    tick(); #1;
    checks++; if (rf_we !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL x0_after got we=%0b occ=%0d exp 0/0", rf_we, occupancy); end
  endtask

  task automatic test_grant_stall;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;
    a0 = 5'($urandom_range(31, 1)); a1 = 5'($urandom_range(31, 1));
    d0 = $urandom; d1 = $urandom;
    rf_grant = 0;
    wb_done = 1; wb_id = 3'd6; wb_rd = {d1, d0}; wb_rd_addr = {a1, a0}; wb_port_valid = 2'b11;
    tick(); idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== a0 || rf_wdata !== d0) begin failures++; $display("FAIL stall_hold%0d got=%0b/%0d/%h exp=1/%0d/%h", k, rf_we, rf_waddr, rf_wdata, a0, d0); end
      checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL stall_noretire%0d got=%0b exp=0", k, retire_valid); end
      tick();
    end
    rf_grant = 1; #1;
    checks++; if (rf_waddr !== a0 || retire_valid !== 1'b0) begin failures++; $display("FAIL stall_g1 got=%0d/%0b exp=%0d/0", rf_waddr, retire_valid, a0); end
    tick(); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== a1 || rf_wdata !== d1) begin failures++; $display("FAIL stall_g2 got=%0b/%0d/%h exp=1/%0d/%h", rf_we, rf_waddr, rf_wdata, a1, d1); end
    checks++; if (retire_valid !== 1'b1 || retire_id !== 3'd6) begin failures++; $display("FAIL stall_retire got=%0b/%0d exp=1/6", retire_valid, retire_id); end
    tick(); rf_grant = 0;
  endtask

  task automatic test_overflow;
    int got[$];
    rf_grant = 0;
    for (int i = 0; i < 5; i++) begin
      wb_done = 1; wb_id = 3'(i); wb_rd = {$urandom, $urandom};
      wb_rd_addr = {5'(i + 9), 5'(i + 1)}; wb_port_valid = 2'b11;
      #1;
      checks++; if (wb_ready !== (i < 4)) begin failures++; $display("FAIL fill_ready%0d got=%0b exp=%0b", i, wb_ready, (i < 4)); end
      tick();
    end
    idle_inputs(); #1;
    checks++; if (overflow_err !== 1'b1 || occupancy !== 3'd4 || wb_ready !== 1'b0) begin failures++; $display("FAIL full_state got ovf=%0b occ=%0d rdy=%0b exp 1/4/0", overflow_err, occupancy, wb_ready); end
    rf_grant = 1;
    for (int c = 0; c < 20; c++) begin
      if (retire_valid === 1'b1) got.push_back(int'(retire_id));
      tick(); #1;
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL ovf_retire_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++; if (got[k] != k) begin failures++; $display("FAIL ovf_retire_order%0d got=%0d exp=%0d", k, got[k], k); end
    end
    checks++; if (overflow_err !== 1'b1 || occupancy !== 3'd0) begin failures++; $display("FAIL ovf_sticky got ovf=%0b occ=%0d exp 1/0", overflow_err, occupancy); end
  endtask

  task automatic test_wraparound;
    logic [4:0] ea[$];
    logic [31:0] ed[$];
    int eid[$];
    int en[$];
    int pushed = 0, cyc = 0, n;
    logic [4:0] a [2];
    logic [31:0] d [2];
    logic [1:0] pv;
    do_reset();
    while ((pushed < 10 || eid.size() > 0) && cyc < 600) begin
      idle_inputs();
      rf_grant = ($urandom_range(3, 0) != 0);
      if (pushed < 10 && eid.size() < DEPTH && $urandom_range(2, 0) != 0) begin
        pv = 2'($urandom_range(3, 0));
        for (int i = 0; i < 2; i++) begin a[i] = 5'($urandom_range(31, 0)); d[i] = $urandom; end
        wb_done = 1; wb_id = 3'($urandom_range(7, 0)); wb_port_valid = pv;
        wb_rd = {d[1], d[0]}; wb_rd_addr = {a[1], a[0]};
      end
      #1;
      checks++; if (occupancy !== 3'(eid.size()) || occupancy > 3'd4) begin failures++; $display("FAIL wrap_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, eid.size()); end
      checks++; if (wb_ready !== (eid.size() < DEPTH)) begin failures++; $display("FAIL wrap_ready cyc=%0d got=%0b exp=%0b", cyc, wb_ready, eid.size() < DEPTH); end
      if (rf_we === 1'b0) begin
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== '0) begin failures++; $display("FAIL wrap_idle_bus cyc=%0d got=%0d/%h exp=0/0", cyc, rf_waddr, rf_wdata); end
      end
      if (rf_we === 1'b1 && rf_grant) begin
        checks++;
        if (ea.size() == 0) begin failures++; $display("FAIL wrap_write cyc=%0d got=%0d/%h exp=none", cyc, rf_waddr, rf_wdata); end
        else begin
          if (rf_waddr !== ea[0] || rf_wdata !== ed[0]) begin failures++; $display("FAIL wrap_write cyc=%0d got=%0d/%h exp=%0d/%h", cyc, rf_waddr, rf_wdata, ea[0], ed[0]); end
          void'(ea.pop_front()); void'(ed.pop_front());
          if (en.size() > 0) en[0] = en[0] - 1;
        end
      end
      if (retire_valid === 1'b1) begin
        checks++;
        if (eid.size() == 0) begin failures++; $display("FAIL wrap_retire cyc=%0d got=%0d exp=none", cyc, retire_id); end
        else begin
          if (retire_id !== 3'(eid[0]) || en[0] != 0) begin failures++; $display("FAIL wrap_retire cyc=%0d got=%0d exp=%0d words_left=%0d", cyc, retire_id, eid[0], en[0]); end
          void'(eid.pop_front()); void'(en.pop_front());
        end
      end
      if (wb_done) begin
        n = 0;
        for (int i = 0; i < 2; i++)
          if (pv[i] && a[i] != 5'd0) begin ea.push_back(a[i]); ed.push_back(d[i]); n++; end
        eid.push_back(int'(wb_id)); en.push_back(n); pushed++;
      end
      tick(); cyc++;
    end
    idle_inputs();
    checks++; if (cyc >= 600 || ea.size() != 0) begin failures++; $display("FAIL wrap_timeout cyc=%0d pending_words=%0d exp drained", cyc, ea.size()); end
  endtask

  task automatic test_async_reset;
    rf_grant = 0;
    for (int i = 0; i < 3; i++) begin
      wb_done = 1; wb_id = 3'(i + 1); wb_rd = {$urandom, $urandom};
      wb_rd_addr = {5'(i + 20), 5'(i + 2)}; wb_port_valid = 2'b11;
      tick();
    end
    idle_inputs(); #1;
    checks++; if (rf_we !== 1'b1 || occupancy !== 3'd3 || overflow_err !== 1'b1) begin failures++; $display("FAIL arst_pre got we=%0b occ=%0d ovf=%0b exp 1/3/1", rf_we, occupancy, overflow_err); end
    #2; rst = 1; #1;
    checks++; if (rf_we !== 1'b0 || retire_valid !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL arst_immediate got we=%0b ret=%0b occ=%0d exp 0/0/0", rf_we, retire_valid, occupancy); end
    @(negedge clk); @(negedge clk); rst = 0;
    tick(); #1;
    checks++; if (occupancy !== 3'd0 || wb_ready !== 1'b1 || overflow_err !== 1'b0) begin failures++; $display("FAIL arst_after got occ=%0d rdy=%0b ovf=%0b exp 0/1/0", occupancy, wb_ready, overflow_err); end
    rf_grant = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL arst_discard%0d got ret=%0b we=%0b exp 0/0", k, retire_valid, rf_we); end
      tick(); #1;
    end
    rf_grant = 0;
  endtask

  initial begin
    idle_inputs(); rf_grant = 0; rst = 0;
    test_reset();
    test_single();
    test_config();
    test_grant_stall();
    test_overflow();
    test_async_reset();
    test_wraparound();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
